mfp_ahb_spi_master: RTL
=======================

Name: mfp_ahb_spi_master

Overview:
AHB-Lite slave that controls a single-byte SPI master (mode 0: CPOL=0, CPHA=0) for the MIPSfpga system.
- Sits on the core's AHB-Lite bus beside the memory/GPIO slaves; the bus decoder drives HSEL.
- Software programs the divider and chip-select through registers, writes DATA to start a transfer, then polls STATUS or takes an interrupt.
- The internal FSM sequences SCK, MOSI and MISO sampling.

Parameters:
DIV_W, 8, width of the SCK divider register.
DIV_RST, 4, CLKDIV reset value.

Ports:
HCLK  in  1  bus clock; the only clock.
HRESETn  in  1  asynchronous active-low reset.
HSEL  in  1  slave select from the bus decoder.
HADDR  in  4  byte address; bits [3:2] select the register.
HTRANS  in  2  transfer type; bit1 set = NONSEQ/SEQ.
HWRITE  in  1  1 = write.
HREADY  in  1  bus ready; qualifies the address phase.
HWDATA  in  32  write data (data phase).
HRDATA  out  32  read data (data phase).
HREADYOUT  out  1  tied 1 (zero wait states).
HRESP  out  1  tied 0 (OKAY).
SPI_SCK  out  1  serial clock, idles low.
SPI_MOSI  out  1  master out.
SPI_MISO  in  1  master in; board timing guarantees setup to HCLK.
SPI_CS_N  out  1  chip select, active low.
SPI_IRQ  out  1  interrupt = STATUS.DONE & CTRL.IE.

Behaviour:
- AHB access
  - Address phase accepted when HSEL & HTRANS[1] & HREADY; HADDR[3:2] and HWRITE are registered.
  - Writes update registers on the clock edge that ends the data phase, using HWDATA.
  - HRDATA is combinational from the registered address during the data phase. Unused bits read 0.
  - HSIZE is ignored; every access is treated as a word.
- Register map
  - 0x0 CTRL (RW, reset 0): bit0 EN, bit1 CS (SPI_CS_N = ~CS), bit2 IE.
  - 0x4 CLKDIV (RW, reset DIV_RST): each SCK half-period lasts CLKDIV+1 HCLK cycles. It is latched into a working copy at transfer start, so writes during BUSY affect only the next transfer.
  - 0x8 DATA:
    - Write with EN=1 and BUSY=0: load TX shift register with HWDATA[7:0] and start a transfer.
    - Write with BUSY=1: ignored, and sets OVR.
    - Write with EN=0: ignored, no flag set.
    - Read: returns the last received byte and clears DONE.
  - 0xC STATUS: bit0 BUSY (RO), bit1 DONE (sticky, W1C), bit2 OVR (sticky, W1C). Reset 0.
- Reset values: SPI_SCK=0, SPI_MOSI=0, SPI_CS_N=1, SPI_IRQ=0, HRDATA=0, FSM=IDLE, RX=0, bit counter=0, divider counter=0.
- FSM states: IDLE, LO, HI.
  - IDLE -> LO on a start write. BUSY=1 from the next cycle. MOSI = tx[7]. Bit count = 7. Divider counter = 0.
  - LO: SCK=0. When divider counter = working CLKDIV: go to HI, set SCK=1, shift MISO into rx[0] (rx shifts left), reset divider counter.
  - HI: SCK=1. When divider counter = working CLKDIV:
    - If bit count = 0: go to IDLE, set SCK=0, copy rx to the DATA read register, set DONE.
    - Otherwise: go to LO, set SCK=0, shift tx left, MOSI = next bit, decrement bit count.
  - MSB first.
- Timing: a transfer takes 16*(CLKDIV+1) HCLK cycles from the first BUSY cycle to the last. BUSY=0 and DONE=1 are visible together in the following cycle.
- Boundary cases
  - EN cleared mid-transfer: abort to IDLE on the next edge. SCK=0, MOSI=0, DONE not set, RX register unchanged.
  - Reset mid-transfer: immediate asynchronous return to the reset values.
  - DONE set and W1C / DATA read in the same cycle: set wins.
  - OVR set and OVR W1C in the same cycle: set wins.
  - CLKDIV=0: SCK frequency is HCLK/2.
  - CLKDIV all ones: the divider counter must not overflow; compare for equality.
  - CS is purely software-controlled; the FSM never toggles SPI_CS_N.

Test Plan:
- Reset -> CTRL=0, CLKDIV=4, STATUS=0, SPI_CS_N=1, SCK=0, SPI_IRQ=0; reads of all four addresses match.
- CTRL=0x3, CLKDIV=0, write DATA=0xA5, MISO looped back to MOSI -> 8 SCK rising edges, BUSY high for exactly 16 cycles, then STATUS=0x2 and DATA read = 0xA5; a subsequent STATUS read = 0x0.
- CLKDIV=3, MISO driven with pattern 0x3C MSB-first on rising edges -> each SCK level lasts 4 cycles, transfer is 64 cycles, RX=0x3C, MOSI matches the TX byte bit-by-bit.
- Second DATA write (0xFF) mid-transfer of 0x81 -> OVR=1, transmitted bits still 0x81; W1C 0x4 clears OVR.
- CTRL.EN cleared at bit 3 -> next cycle BUSY=0, SCK=0, DONE=0, RX read = previous value; with IE=1 after a normal transfer -> SPI_IRQ=1 until DONE is cleared.
- HRESETn asserted mid-HI state -> outputs take reset values asynchronously; after release, a new 0x5A transfer completes normally.

Source files
------------

// File: rtl/mfp_ahb_spi_master.sv
// AHB-Lite slave wrapping a mode-0, single-byte SPI master for the MIPSfpga system.
// Software programs CLKDIV/CTRL, writes DATA to shift one byte MSB first, then polls STATUS or takes SPI_IRQ.
`timescale 1ns/1ps

module mfp_ahb_spi_master #(
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [3:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        SPI_SCK,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO,
  output logic        SPI_CS_N,
  output logic        SPI_IRQ
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_e;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_DIV  = 2'd1;
  localparam logic [1:0] ADDR_DATA = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  logic             valid_q, write_q;
  logic [1:0]       addr_q;
  state_e           state_q, state_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [DIV_W-1:0] clkdiv_q, clkdiv_d;
  logic [DIV_W-1:0] divWork_q, divWork_d;
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       rxData_q, rxData_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             busy, wrEn, rdData, divHit, doneSet, ovrSet;
  logic             unusedBits;

  assign busy   = (state_q != IDLE);
  assign wrEn   = valid_q & write_q;
  assign rdData = valid_q & ~write_q & (addr_q == ADDR_DATA);
  // Equality compare keeps the all-ones divider from wrapping the counter.
  assign divHit = (divCnt_q == divWork_q);

  assign unusedBits = &{1'b0, HADDR[1:0], HTRANS[0], HWDATA};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 2'd0;
    end else if (HREADY) begin
      valid_q <= HSEL & HTRANS[1];
      write_q <= HWRITE;
      addr_q  <= HADDR[3:2];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      ctrl_q    <= 3'd0;
      clkdiv_q  <= DIV_W'(DIV_RST);
      divWork_q <= '0;
      divCnt_q  <= '0;
      bitCnt_q  <= 3'd0;
      tx_q      <= 8'd0;
      rx_q      <= 8'd0;
      rxData_q  <= 8'd0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      clkdiv_q  <= clkdiv_d;
      divWork_q <= divWork_d;
      divCnt_q  <= divCnt_d;
      bitCnt_q  <= bitCnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rxData_q  <= rxData_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    clkdiv_d  = clkdiv_q;
    divWork_d = divWork_q;
    divCnt_d  = divCnt_q;
    bitCnt_d  = bitCnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rxData_d  = rxData_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    doneSet   = 1'b0;
    ovrSet    = 1'b0;

    if (wrEn && addr_q == ADDR_CTRL) ctrl_d = HWDATA[2:0];
    if (wrEn && addr_q == ADDR_DIV) clkdiv_d = HWDATA[DIV_W-1:0];
    if (wrEn && addr_q == ADDR_DATA && busy) ovrSet = 1'b1;

    case (state_q)
      IDLE: begin
        if (wrEn && addr_q == ADDR_DATA && ctrl_q[0]) begin
          state_d   = LO;
          tx_d      = HWDATA[7:0];
          mosi_d    = HWDATA[7];
          bitCnt_d  = 3'd7;
          divCnt_d  = '0;
          divWork_d = clkdiv_q;
        end
      end
      LO: begin
        if (divHit) begin
          state_d  = HI;
          sck_d    = 1'b1;
          rx_d     = {rx_q[6:0], SPI_MISO};
          divCnt_d = '0;
        end else begin
          divCnt_d = divCnt_q + DIV_W'(1);
        end
      end
      HI: begin
        if (divHit) begin
          sck_d    = 1'b0;
          divCnt_d = '0;
          if (bitCnt_q == 3'd0) begin
            state_d  = IDLE;
            rxData_d = rx_q;
            doneSet  = 1'b1;
          end else begin
            state_d  = LO;
            tx_d     = {tx_q[6:0], 1'b0};
            mosi_d   = tx_q[6];
            bitCnt_d = bitCnt_q - 3'd1;
          end
        end else begin
          divCnt_d = divCnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Dropping EN abandons the byte: no DONE, and the readable RX byte stays as it was.
    if (busy && !ctrl_q[0]) begin
      state_d  = IDLE;
      sck_d    = 1'b0;
      mosi_d   = 1'b0;
      divCnt_d = '0;
      bitCnt_d = 3'd0;
      rxData_d = rxData_q;
      doneSet  = 1'b0;
    end

    done_d = done_q;
    if (rdData || (wrEn && addr_q == ADDR_STAT && HWDATA[1])) done_d = 1'b0;
    if (doneSet) done_d = 1'b1;

    ovr_d = ovr_q;
    if (wrEn && addr_q == ADDR_STAT && HWDATA[2]) ovr_d = 1'b0;
    if (ovrSet) ovr_d = 1'b1;
  end

  always_comb begin
    HRDATA = 32'd0;
    if (valid_q && !write_q) begin
      case (addr_q)
        ADDR_CTRL: HRDATA[2:0]       = ctrl_q;
        ADDR_DIV:  HRDATA[DIV_W-1:0] = clkdiv_q;
        ADDR_DATA: HRDATA[7:0]       = rxData_q;
        default:   HRDATA[2:0]       = {ovr_q, done_q, busy};
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign SPI_SCK   = sck_q;
  assign SPI_MOSI  = mosi_q;
  assign SPI_CS_N  = ~ctrl_q[1];
  assign SPI_IRQ   = done_q & ctrl_q[2];

endmodule
